hiscore_ram_port: RTL and testbench
===================================

# hiscore_ram_port

Game-core-side responder for the high-score save/restore interface. Takes the hiscore engine's RAM requests (address, write data, write strobe, access flag) and gains exclusive ownership of the CPU work RAM through a pause-request/acknowledge handshake. While it owns the RAM it performs the engine's reads and writes, then hands the RAM back to the CPU. Sits inside the system core between the CPU bus, the work-RAM block and the top-level hiscore engine.

## Interface
Parameters:
- `HS_AW`, 16, width of the hiscore engine address.
- `RAM_AW`, 11, work-RAM address width (2 KiB).
- `RAM_BASE`, 16'hC000, CPU address where work RAM starts; the window is `RAM_BASE .. RAM_BASE + 2^RAM_AW - 1`.

Ports:
- `clk_sys`  in  1  system clock (40 MHz); the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `hs_access`  in  1  engine requests RAM ownership (level).
- `hs_address`  in  HS_AW  engine CPU-space address.
- `hs_data_in`  in  8  engine write data.
- `hs_write`  in  1  engine write strobe, one cycle per byte.
- `hs_data_out`  out  8  read data returned to the engine.
- `hs_owned`  out  1  high while this block drives the RAM.
- `pause_req`  out  1  request for the CPU to stop at a bus boundary.
- `cpu_paused`  in  1  CPU acknowledge: bus idle and halted.
- `cpu_addr`  in  RAM_AW  CPU RAM address.
- `cpu_din`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write enable.
- `cpu_dout`  out  8  RAM read data to the CPU.
- `ram_addr`  out  RAM_AW  muxed RAM address.
- `ram_din`  out  8  muxed RAM write data.
- `ram_we`  out  1  muxed RAM write enable.
- `ram_dout`  in  8  RAM read data (synchronous RAM, 1-cycle latency).
- `drop_cnt`  out  8  saturating count of engine writes rejected.

## Operation
- FSM states: IDLE, REQ, OWN, REL.
  - IDLE: `pause_req`=0. Goes to REQ when `hs_access`=1.
  - REQ: `pause_req`=1. Goes to OWN when `cpu_paused`=1. If `hs_access` drops first, goes to REL.
  - OWN: `pause_req`=1, `hs_owned`=1. Goes to REL when `hs_access`=0.
  - REL: `pause_req`=0, `hs_owned`=0. Goes to IDLE when `cpu_paused`=0.
- RAM mux:
  - In OWN: `ram_addr` = `hs_address[RAM_AW-1:0]` - `RAM_BASE[RAM_AW-1:0]` (modulo 2^RAM_AW); `ram_din` = `hs_data_in`.
  - In all other states: `ram_addr`/`ram_din`/`ram_we` = `cpu_addr`/`cpu_din`/`cpu_we`, passed through combinationally.
- In-window test: `hs_address` >= `RAM_BASE` and `hs_address` - `RAM_BASE` < 2^RAM_AW, computed at HS_AW+1 bits so there is no wrap.
- Engine writes:
  - `hs_write` in OWN and in window gives a one-cycle `ram_we`.
  - Any other `hs_write` (wrong state or out of window) produces no RAM write and increments `drop_cnt`, which saturates at 255.
- Engine reads:
  - `hs_data_out` = registered `ram_dout` when the previous cycle's address was in window and the state was OWN.
  - Otherwise `hs_data_out` = 8'hFF.
- `cpu_dout` = `ram_dout`, always.
- Reset mid-operation: everything returns to IDLE asynchronously and `pause_req` drops immediately. Any RAM write in flight is abandoned.

## Timing
- Reset values: state IDLE; `pause_req`=0, `hs_owned`=0, `hs_data_out`=8'hFF, `drop_cnt`=0.
- `ram_we`/`ram_addr`/`ram_din` follow their mux sources combinationally; state is registered.
- `pause_req` rises 1 cycle after `hs_access` rises.
- OWN is entered 1 cycle after `cpu_paused` is sampled high.
- Read latency: address presented in cycle N, RAM data in N+1, `hs_data_out` valid in N+2.
- Write: `hs_write` in cycle N gives `ram_we` in cycle N, with no wait state.
- Simultaneous `hs_write` and the cycle `hs_access` falls while in OWN: the write is performed and the state goes to REL.
- Simultaneous `cpu_we` while in OWN: ignored. The CPU is paused by protocol, and the block does not count it.

## Test plan
- Ownership: `hs_access`↑ at t0 → `pause_req`=1 at t0+1; `cpu_paused`↑ at t5 → `hs_owned`=1 at t6.
- Write: in OWN, `hs_address`=16'hC123, `hs_data_in`=8'h5A, `hs_write`=1 → `ram_we`=1, `ram_addr`=11'h123, `ram_din`=8'h5A in the same cycle.
- Read: in OWN, address 16'hC7FF with RAM holding 8'hA5 → `hs_data_out`=8'hA5 two cycles later. Address 16'hC800 → `hs_data_out`=8'hFF.
- Drops: 300 `hs_write` pulses while in IDLE → no `ram_we` from the engine side, `drop_cnt`=255.
- Abort and release: `hs_access`↓ while in REQ → `pause_req`=0 next cycle; the state waits in REL until `cpu_paused`=0, then returns to IDLE.
- Async reset asserted while in OWN mid-write → `pause_req`, `hs_owned` and `ram_we` go to 0 immediately without a clock edge, and `hs_data_out`=8'hFF.

Source files
------------

// File: rtl/hiscore_ram_port.sv
// Work-RAM port for the hiscore engine: pauses the CPU, takes over the work RAM,
// performs engine reads/writes inside the RAM window, then hands the RAM back.
module hiscore_ram_port #(
    parameter int unsigned          HS_AW    = 16,
    parameter int unsigned          RAM_AW   = 11,
    parameter logic [HS_AW-1:0]     RAM_BASE = 16'hC000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              hs_access,
    input  logic [HS_AW-1:0]  hs_address,
    input  logic [7:0]        hs_data_in,
    input  logic              hs_write,
    output logic [7:0]        hs_data_out,
    output logic              hs_owned,
    output logic              pause_req,
    input  logic              cpu_paused,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dout,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned     CW       = HS_AW + 1;
    localparam logic [CW-1:0]   WIN_SIZE = CW'(1) << RAM_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        pause_req_q, pause_req_d;
    logic        hs_owned_q, hs_owned_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  hs_data_out_q, hs_data_out_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] hs_off;
    logic          in_window;
    logic          own;
    logic          eng_we;

    // Window test at HS_AW+1 bits so addresses below RAM_BASE cannot wrap into range.
    assign hs_off    = {1'b0, hs_address} - {1'b0, RAM_BASE};
    assign in_window = (hs_address >= RAM_BASE) && (hs_off < WIN_SIZE);
    assign own       = (state_q == OWN);
    assign eng_we    = own && in_window && hs_write;

    always_comb begin
        state_d       = state_q;
        drop_cnt_d    = drop_cnt_q;
        rd_valid_d    = own && in_window;
        hs_data_out_d = rd_valid_q ? ram_dout : 8'hFF;
        ram_addr      = cpu_addr;
        ram_din       = cpu_din;
        ram_we        = cpu_we;

        unique case (state_q)
            IDLE: if (hs_access) state_d = REQ;
            REQ: begin
                if (!hs_access)      state_d = REL;
                else if (cpu_paused) state_d = OWN;
            end
            OWN: if (!hs_access)  state_d = REL;
            REL: if (!cpu_paused) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // While owned the engine drives the RAM; the paused CPU's strobes are ignored.
        if (own) begin
            ram_addr = hs_address[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
            ram_din  = hs_data_in;
            ram_we   = eng_we;
        end

        if (hs_write && !eng_we && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;

        pause_req_d = (state_d == REQ) || (state_d == OWN);
        hs_owned_d  = (state_d == OWN);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pause_req_q   <= 1'b0;
            hs_owned_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            hs_data_out_q <= 8'hFF;
            drop_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            pause_req_q   <= pause_req_d;
            hs_owned_q    <= hs_owned_d;
            rd_valid_q    <= rd_valid_d;
            hs_data_out_q <= hs_data_out_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign pause_req   = pause_req_q;
    assign hs_owned    = hs_owned_q;
    assign hs_data_out = hs_data_out_q;
    assign drop_cnt    = drop_cnt_q;
    assign cpu_dout    = ram_dout;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Directed bench for hiscore_ram_port with a behavioural 2 KiB synchronous work RAM.
`timescale 1ns/1ps
module tb_hiscore_ram_port;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        hs_access;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic [7:0]  hs_data_out;
    logic        hs_owned;
    logic        pause_req;
    logic        cpu_paused;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  drop_cnt;

    logic [7:0]  mem [0:2047];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_sys = ~clk_sys;

    hiscore_ram_port dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .hs_access  (hs_access),
        .hs_address (hs_address),
        .hs_data_in (hs_data_in),
        .hs_write   (hs_write),
        .hs_data_out(hs_data_out),
        .hs_owned   (hs_owned),
        .pause_req  (pause_req),
        .cpu_paused (cpu_paused),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_we     (cpu_we),
        .cpu_dout   (cpu_dout),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .drop_cnt   (drop_cnt)
    );

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    int we_seen;

    initial begin
        reset = 1'b1; hs_access = 1'b0; hs_address = 16'h0000; hs_data_in = 8'h00;
        hs_write = 1'b0; cpu_paused = 1'b0; cpu_addr = 11'h000; cpu_din = 8'h00; cpu_we = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        step(2);
        check("rst_pause_req", 32'(pause_req), 32'd0);
        check("rst_hs_owned", 32'(hs_owned), 32'd0);
        check("rst_hs_data_out", 32'(hs_data_out), 32'hFF);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        step(1);

        // Ownership handshake
        hs_access = 1'b1;
        #1 check("pause_req_same_cycle", 32'(pause_req), 32'd0);
        step(1);
        check("pause_req_t1", 32'(pause_req), 32'd1);
        step(3);
        cpu_paused = 1'b1;
        #1 check("hs_owned_before_ack_edge", 32'(hs_owned), 32'd0);
        step(1);
        check("hs_owned_t6", 32'(hs_owned), 32'd1);
        check("first_own_read_ff", 32'(hs_data_out), 32'hFF);

        // Engine write with a simultaneous CPU write that must be ignored
        hs_address = 16'hC123; hs_data_in = 8'h5A; hs_write = 1'b1;
        cpu_addr = 11'h055; cpu_din = 8'h11; cpu_we = 1'b1;
        #1;
        check("wr_ram_we", 32'(ram_we), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'h123);
        check("wr_ram_din", 32'(ram_din), 32'h5A);
        step(1);
        cpu_we = 1'b0;
        hs_address = 16'hC7FF; hs_data_in = 8'hA5;
        step(1);
        check("mem_123", 32'(mem[11'h123]), 32'h5A);
        check("cpu_write_ignored", 32'(mem[11'h055]), 32'h00);
        check("drop_cnt_after_good_wr", 32'(drop_cnt), 32'd0);

        // Out-of-window writes just above and below the window
        hs_address = 16'hC800; hs_data_in = 8'hEE;
        #1 check("oow_hi_ram_we", 32'(ram_we), 32'd0);
        step(1);
        hs_address = 16'hBFFF;
        #1 check("oow_lo_ram_we", 32'(ram_we), 32'd0);
        step(1);
        hs_write = 1'b0;
        check("drop_cnt_oow", 32'(drop_cnt), 32'd2);
        check("mem_000_untouched", 32'(mem[11'h000]), 32'h00);

        // Reads: two-cycle latency, FF outside the window
        hs_address = 16'hC7FF;
        step(1);
        check("rd_not_yet", 32'(hs_data_out), 32'hFF);
        hs_address = 16'hC123;
        step(1);
        check("rd_c7ff", 32'(hs_data_out), 32'hA5);
        hs_address = 16'hC800;
        step(1);
        check("rd_c123", 32'(hs_data_out), 32'h5A);
        step(1);
        check("rd_c800_ff", 32'(hs_data_out), 32'hFF);

        // Last write coincides with hs_access falling
        hs_address = 16'hC010; hs_data_in = 8'h3C; hs_write = 1'b1; hs_access = 1'b0;
        #1 check("last_wr_ram_we", 32'(ram_we), 32'd1);
        step(1);
        hs_write = 1'b0;
        check("last_wr_mem", 32'(mem[11'h010]), 32'h3C);
        check("rel_hs_owned", 32'(hs_owned), 32'd0);
        check("rel_pause_req", 32'(pause_req), 32'd0);
        cpu_addr = 11'h066; cpu_din = 8'h77; cpu_we = 1'b1;
        #1;
        check("rel_cpu_passthru_we", 32'(ram_we), 32'd1);
        check("rel_cpu_passthru_addr", 32'(ram_addr), 32'h066);
        step(1);
        cpu_we = 1'b0;
        check("cpu_dout_passthru", 32'(cpu_dout), 32'(ram_dout));
        cpu_paused = 1'b0;
        step(1);

        // Drops in IDLE saturate at 255
        we_seen = 0;
        hs_address = 16'hC200;
        for (int i = 0; i < 300; i++) begin
            hs_write = 1'b1;
            #1 if (ram_we) we_seen++;
            step(1);
            if (i == 9) check("drop_cnt_12", 32'(drop_cnt), 32'd12);
        end
        hs_write = 1'b0;
        check("idle_no_engine_we", 32'(we_seen), 32'd0);
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        check("idle_pause_req", 32'(pause_req), 32'd0);

        // Abort from REQ; REL waits for cpu_paused to drop
        hs_access = 1'b1;
        step(1);
        check("abort_req_pause", 32'(pause_req), 32'd1);
        hs_access = 1'b0;
        step(1);
        check("abort_pause_drop", 32'(pause_req), 32'd0);
        cpu_paused = 1'b1; hs_access = 1'b1;
        step(2);
        check("rel_wait_pause", 32'(pause_req), 32'd0);
        check("rel_wait_owned", 32'(hs_owned), 32'd0);
        cpu_paused = 1'b0;
        step(1);
        check("back_idle_pause", 32'(pause_req), 32'd0);
        step(1);
        check("idle_to_req_pause", 32'(pause_req), 32'd1);

        // Async reset in OWN mid-write
        cpu_paused = 1'b1;
        step(1);
        check("own_again", 32'(hs_owned), 32'd1);
        hs_address = 16'hC400; hs_data_in = 8'h99; hs_write = 1'b1;
        #1 check("pre_rst_ram_we", 32'(ram_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_pause_req", 32'(pause_req), 32'd0);
        check("arst_hs_owned", 32'(hs_owned), 32'd0);
        check("arst_ram_we", 32'(ram_we), 32'd0);
        check("arst_hs_data_out", 32'(hs_data_out), 32'hFF);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        hs_write = 1'b0; hs_access = 1'b0; cpu_paused = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
